// File: rtl/uart_host_endpoint.sv
// uart_host_endpoint: full-duplex 8N1 UART endpoint facing a CPU serial port.
// Define UART_HOST_PARITY_EN to add an even-parity bit (11-bit frames).
module uart_host_endpoint #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } st_t;

  st_t           txs;
  logic [CW-1:0] tcnt;
  logic [2:0]    tbit;
  logic [7:0]    tsh;
  logic          tend;
`ifdef UART_HOST_PARITY_EN
  logic          tpar;
`endif

  assign tend = (tcnt == LAST);

  // Transmit FSM: latches the byte at accept, shifts it out LSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      txs      <= IDLE;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tcnt     <= '0;
      tbit     <= '0;
      tsh      <= '0;
`ifdef UART_HOST_PARITY_EN
      tpar     <= 1'b0;
`endif
    end else begin
      tcnt <= (txs == IDLE || tend) ? '0 : tcnt + CW'(1);
      unique case (txs)
        IDLE: if (tx_valid) begin
          txs      <= START;
          tx       <= 1'b0;
          tx_ready <= 1'b0;
          tsh      <= tx_data;
          tbit     <= '0;
`ifdef UART_HOST_PARITY_EN
          tpar     <= ^tx_data;
`endif
        end
        START: if (tend) begin
          txs <= DATA;
          tx  <= tsh[0];
        end
        DATA: if (tend) begin
          tbit <= tbit + 3'd1;
          tsh  <= {1'b0, tsh[7:1]};
          if (tbit == 3'd7) begin
`ifdef UART_HOST_PARITY_EN
            txs <= PARITY;
            tx  <= tpar;
`else
            txs <= STOP;
            tx  <= 1'b1;
`endif
          end else begin
            tx <= tsh[1];
          end
        end
        PARITY: begin
`ifdef UART_HOST_PARITY_EN
          if (tend) begin
            txs <= STOP;
            tx  <= 1'b1;
          end
`else
          txs <= IDLE;
`endif
        end
        STOP: if (tend) begin
          txs      <= IDLE;
          tx_ready <= 1'b1;
        end
        default: txs <= IDLE;
      endcase
    end
  end

  logic s1, s2, s3;

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rx;
      s2 <= s1;
      s3 <= s2;
    end
  end

  st_t           rxs;
  logic [CW-1:0] rcnt;
  logic [2:0]    rbit;
  logic [7:0]    rsh;
  logic          rtick;
`ifdef UART_HOST_PARITY_EN
  logic          rpbad;
`endif

  assign rtick = (rxs == START) ? (rcnt == MID) : (rcnt == LAST);

  // Receive FSM: mid-bit sampling, returns to IDLE at the stop sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxs          <= IDLE;
      rcnt         <= '0;
      rbit         <= '0;
      rsh          <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_HOST_PARITY_EN
      rpbad         <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_HOST_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
      rcnt <= (rxs == IDLE || rtick) ? '0 : rcnt + CW'(1);
      unique case (rxs)
        IDLE: if (s3 && !s2) rxs <= START;
        START: if (rtick) begin
          if (s2) begin
            rxs <= IDLE;
          end else begin
            rxs  <= DATA;
            rbit <= '0;
          end
        end
        DATA: if (rtick) begin
          rsh  <= {s2, rsh[7:1]};
          rbit <= rbit + 3'd1;
          if (rbit == 3'd7) begin
`ifdef UART_HOST_PARITY_EN
            rxs <= PARITY;
`else
            rxs <= STOP;
`endif
          end
        end
        PARITY: begin
`ifdef UART_HOST_PARITY_EN
          if (rtick) begin
            rpbad <= (^rsh) != s2;
            rxs   <= STOP;
          end
`else
          rxs <= IDLE;
`endif
        end
        STOP: if (rtick) begin
          rxs          <= IDLE;
          rx_frame_err <= !s2;
`ifdef UART_HOST_PARITY_EN
          rx_parity_err <= rpbad;
          if (s2 && !rpbad) begin
`else
          if (s2) begin
`endif
            rx_data  <= rsh;
            rx_valid <= 1'b1;
          end
        end
        default: rxs <= IDLE;
      endcase
    end
  end

`ifndef UART_HOST_PARITY_EN
  assign rx_parity_err = 1'b0;
`endif

endmodule
